irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, maskable, strictly prioritised interrupt controller with
// nesting, a take/vector handshake toward the CPU and a small W1C register file.
module irq_ctrl #(
  parameter int          N_SRC      = 8,
  parameter logic [15:0] VEC_BASE   = 16'h0020,
  parameter logic [15:0] VEC_STRIDE = 16'h0004,
  parameter int          MAX_NEST   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SRC-1:0] i_irq_src,
  input  logic             i_int_en,
  input  logic             i_in_irq,
  input  logic             i_iret,
  output logic             o_irq_take,
  output logic [15:0]      o_irq_vector,
  input  logic             i_wr_en,
  input  logic [1:0]       i_addr,
  input  logic [15:0]      i_wdata,
  output logic [15:0]      o_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_SETTLE} state_t;
  state_t           r_state, w_state_nx;
  logic [N_SRC-1:0] r_prev, r_mask, r_pend, r_active;
  logic             r_armed;
  logic [1:0]       r_nest, r_stale;
  logic [3:0]       r_last;
  logic [15:0]      r_vec;
  logic [N_SRC-1:0] w_rise, w_req, w_cand_oh, w_act_oh, w_w1c, w_wmask;
  logic [3:0]       w_cand, w_act_idx;
  logic             w_cand_vld, w_act_vld, w_take, w_iret_clr, w_stale, w_resync, w_unused;
  logic [15:0]      w_status;
  assign w_wmask  = i_wdata[N_SRC-1:0];
  assign w_unused = ^i_wdata;
  // r_armed suppresses the first compare after reset so a line already high is not an edge
  assign w_rise     = r_armed ? (i_irq_src & ~r_prev) : '0;
  assign w_req      = r_pend & r_mask;
  assign w_cand_vld = |w_req;
  assign w_act_vld  = |r_active;
  assign w_w1c      = (i_wr_en && i_addr == 2'd1) ? w_wmask : '0;
  always_comb begin
    w_cand    = '0;
    w_cand_oh = '0;
    w_act_idx = '0;
    w_act_oh  = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_req[k]) begin
        w_cand       = 4'(k);
        w_cand_oh    = '0;
        w_cand_oh[k] = 1'b1;
      end
      if (r_active[k]) begin
        w_act_idx   = 4'(k);
        w_act_oh    = '0;
        w_act_oh[k] = 1'b1;
      end
    end
  end
  assign w_take = (r_state == S_IDLE) && i_int_en && !i_iret && w_cand_vld &&
                  ({30'd0, r_nest} < 32'(MAX_NEST)) && (!w_act_vld || w_cand < w_act_idx);
  assign w_iret_clr = i_iret && w_act_vld;
  // CPU claims to be out of any handler while we still track active ones: resync on the third cycle
  assign w_stale  = (r_state != S_TAKE) && !i_in_irq && w_act_vld && !w_take;
  assign w_resync = w_stale && r_stale == 2'd2;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  always_comb
    w_state_nx = (r_state == S_IDLE) ? (w_take ? S_TAKE : S_IDLE) :
                 (r_state == S_TAKE) ? S_SETTLE : S_IDLE;
  always_comb o_irq_take = (r_state == S_TAKE);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_prev   <= '0;
      r_armed  <= 1'b0;
      r_mask   <= '0;
      r_pend   <= '0;
      r_active <= '0;
      r_nest   <= '0;
      r_stale  <= '0;
      r_last   <= '0;
      r_vec    <= VEC_BASE;
    end else begin
      r_prev  <= i_irq_src;
      r_armed <= 1'b1;
      if (i_wr_en && i_addr == 2'd0) r_mask <= w_wmask;
      r_pend  <= (r_pend & ~w_w1c & ~(w_take ? w_cand_oh : '0)) | w_rise;
      r_stale <= (w_stale && !w_resync) ? r_stale + 2'd1 : '0;
      if (w_resync) begin
        r_active <= '0;
        r_nest   <= '0;
      end else if (w_take) begin
        r_active <= r_active | w_cand_oh;
        r_nest   <= r_nest + 2'd1;
        r_vec    <= VEC_BASE + VEC_STRIDE * {12'd0, w_cand};
        r_last   <= w_cand;
      end else if (w_iret_clr) begin
        r_active <= r_active & ~w_act_oh;
        r_nest   <= r_nest - 2'd1;
      end
    end
  assign w_status     = {8'd0, r_last, 1'b0, r_state != S_IDLE, r_nest};
  assign o_irq_vector = r_vec;
  always_comb
    o_rdata = (i_addr == 2'd0) ? 16'(r_mask) :
              (i_addr == 2'd1) ? 16'(r_pend) :
              (i_addr == 2'd2) ? 16'(r_active) : w_status;
endmodule
